// File: rtl/partition_sweep_pkg.sv
// rtl/partition_sweep_pkg.sv - shared FSM state type and popcount helper for partition_sweep
package partition_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OUT,
        ST_DONE
    } sweep_state_e;

    localparam int POP_W = 32;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sweep_hd_acc.sv
// rtl/sweep_hd_acc.sv - Hamming-distance accumulator of response vs golden value
// Instantiated by partition_sweep only when SWEEP_HD_EN is defined.
module sweep_hd_acc
    import partition_sweep_pkg::*;
#(
    parameter int NO = 4,
    parameter int W  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          sample_i,
    input  logic [NO-1:0] po_i,
    input  logic [NO-1:0] gold_i,
    output logic [W-1:0]  hd_sum
);

    logic [W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (sample_i) begin
            sum_d = sum_q + W'(popcount(POP_W'(po_i ^ gold_i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign hd_sum = sum_q;

endmodule

// File: rtl/partition_sweep.sv
// rtl/partition_sweep.sv - exhaustive stimulus sweep of a combinational partition with response stream
// Optional Hamming-distance accumulation against gold_i under macro SWEEP_HD_EN.
module partition_sweep
    import partition_sweep_pkg::*;
#(
    parameter int NI     = 7,
    parameter int NO     = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [NI-1:0] pi_o,
    input  logic [NO-1:0] po_i,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [NI-1:0] rsp_pat,
    output logic [NO-1:0] rsp_data
`ifdef SWEEP_HD_EN
    ,
    input  logic [NO-1:0] gold_i,
    output logic [NI+$clog2(NO+1)-1:0] hd_sum
`endif
);

    localparam logic [NI-1:0] PAT_MAX  = '1;
    localparam logic [7:0]    CNT_LAST = 8'(SETTLE - 1);

    sweep_state_e  state_q, state_d;
    logic [NI-1:0] pat_q, pat_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [NI-1:0] rsp_pat_q, rsp_pat_d;
    logic [NO-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        valid_d    = valid_q;
        rsp_pat_d  = rsp_pat_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_OUT;
                    rsp_data_d = po_i;
                    rsp_pat_d  = pat_q;
                    valid_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_OUT: begin
                // abort outranks a handshake landing on the same edge
                if (abort) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (rsp_ready) begin
                    valid_d = 1'b0;
                    if (pat_q == PAT_MAX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        pat_d   = pat_q + 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            rsp_pat_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            rsp_pat_q  <= rsp_pat_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign pi_o      = pat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rsp_valid = valid_q;
    assign rsp_pat   = rsp_pat_q;
    assign rsp_data  = rsp_data_q;

`ifdef SWEEP_HD_EN
    logic hd_clear, hd_sample;

    assign hd_clear  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign hd_sample = (state_q == ST_SETTLE) && !abort && (cnt_q == CNT_LAST);

    sweep_hd_acc #(
        .NO (NO),
        .W  (NI + $clog2(NO + 1))
    ) u_hd_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (hd_clear),
        .sample_i (hd_sample),
        .po_i     (po_i),
        .gold_i   (gold_i),
        .hd_sum   (hd_sum)
    );
`endif

endmodule

// File: tb/tb_partition_sweep.sv
// tb/tb_partition_sweep.sv - self-checking bench for partition_sweep (NI=7 adder partition, NI=1 SETTLE=3 instance)
module tb_partition_sweep;

    localparam int NI   = 7;
    localparam int NO   = 4;
    localparam int NPAT = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, rsp_ready;
    logic          busy, done, rsp_valid;
    logic [NI-1:0] pi_o, rsp_pat;
    logic [NO-1:0] po_i, rsp_data;

    logic          start2, abort2, rsp_ready2;
    logic          busy2, done2, rsp_valid2;
    logic [0:0]    pi2, rsp_pat2, po2, rsp_data2;

    int checks = 0;
    int passes = 0;

    // partition under test: sum of two 3-bit fields plus a carry bit
    assign po_i = 4'(pi_o[2:0]) + 4'(pi_o[5:3]) + 4'(pi_o[6]);
    assign po2  = ~pi2;

`ifdef SWEEP_HD_EN
    logic          gold_inv;
    logic [NO-1:0] gold_i;
    logic [NI+2:0] hd_sum;
    logic [1:0]    hd_sum2;
    assign gold_i = po_i ^ {3'b000, gold_inv};
`endif

    partition_sweep #(.NI(NI), .NO(NO), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .pi_o(pi_o), .po_i(po_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_pat(rsp_pat), .rsp_data(rsp_data)
`ifdef SWEEP_HD_EN
        , .gold_i(gold_i), .hd_sum(hd_sum)
`endif
    );

    partition_sweep #(.NI(1), .NO(1), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .pi_o(pi2), .po_i(po2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_pat(rsp_pat2), .rsp_data(rsp_data2)
`ifdef SWEEP_HD_EN
        , .gold_i(po2), .hd_sum(hd_sum2)
`endif
    );

    function automatic logic [NO-1:0] ref_out(input int p);
        int s;
        s = (p % 8) + ((p / 8) % 8) + (p / 64);
        return NO'(s);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rsp_valid, pi_o, rsp_pat, rsp_data} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b pi=%0d pat=%0d data=%0d, want all 0",
                     busy, done, rsp_valid, pi_o, rsp_pat, rsp_data);
        else passes++;
        checks++;
        if ({busy2, done2, rsp_valid2, pi2, rsp_pat2, rsp_data2} !== '0)
            $display("FAIL reset_outputs2: got %b, want 0", {busy2, done2, rsp_valid2, pi2, rsp_pat2, rsp_data2});
        else passes++;
`ifdef SWEEP_HD_EN
        checks++;
        if (hd_sum !== '0) $display("FAIL reset_hd_sum: got %0d, want 0", hd_sum);
        else passes++;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs a sweep from start; abort_at >= 0 aborts when that pattern is presented.
    task automatic sweep(input bit rand_ready, input int abort_at, output int nresp);
        int  exp_pat = 0;
        int  cyc = 0;
        int  last_hs = -1;
        bit  stall = 1'b0;
        bit  fin = 1'b0;
        logic [NI-1:0] hp = '0;
        logic [NO-1:0] hdat = '0;
        nresp = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 2000) begin
            start = rand_ready && ($urandom_range(0, 15) == 0);
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                checks++;
                if ({rsp_valid, rsp_pat, rsp_data} !== {1'b1, hp, hdat})
                    $display("FAIL stall_stable: got valid=%b pat=%0d data=%0d, want valid=1 pat=%0d data=%0d",
                             rsp_valid, rsp_pat, rsp_data, hp, hdat);
                else passes++;
            end
            if (rsp_valid) begin
                if (nresp == 0 && !stall) begin
                    checks++;
                    if (cyc !== 2) $display("FAIL first_latency: got %0d cycles, want 2", cyc);
                    else passes++;
                end
                if (!stall) begin
                    checks++;
                    if (rsp_pat !== NI'(exp_pat)) $display("FAIL rsp_pat: got %0d, want %0d", rsp_pat, exp_pat);
                    else passes++;
                    checks++;
                    if (rsp_data !== ref_out(exp_pat))
                        $display("FAIL rsp_data: pat %0d got %0d, want %0d", exp_pat, rsp_data, ref_out(exp_pat));
                    else passes++;
                end
                if (exp_pat == abort_at) begin
                    rsp_ready = 1'b1;
                    abort = 1'b1;
                end else if (rsp_ready) begin
                    if (!rand_ready && nresp > 0) begin
                        checks++;
                        if (cyc - last_hs !== 2) $display("FAIL throughput: got %0d cycles, want 2", cyc - last_hs);
                        else passes++;
                    end
                    last_hs = cyc;
                    nresp++;
                    exp_pat++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    hp = rsp_pat;
                    hdat = rsp_data;
                end
            end
            @(negedge clk);
            cyc++;
            if (abort) begin
                abort = 1'b0;
                rsp_ready = 1'b0;
                checks++;
                if ({busy, done, rsp_valid, pi_o} !== '0)
                    $display("FAIL abort_state: got busy=%b done=%b valid=%b pi=%0d, want all 0",
                             busy, done, rsp_valid, pi_o);
                else passes++;
                fin = 1'b1;
            end else if (nresp == NPAT) begin
                start = 1'b0;
                checks++;
                if ({done, busy, rsp_valid} !== 3'b100)
                    $display("FAIL done_after_last: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, rsp_valid);
                else passes++;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            $display("FAIL sweep_timeout: got %0d responses, want %0d", nresp, NPAT);
        end
    endtask

    task automatic test_full_sweep();
        int n;
        sweep(1'b0, -1, n);
        checks++;
        if (n !== NPAT) $display("FAIL full_count: got %0d, want %0d", n, NPAT);
        else passes++;
    endtask

    task automatic test_random_ready();
        int n;
        sweep(1'b1, -1, n);
        checks++;
        if (n !== NPAT) $display("FAIL random_count: got %0d, want %0d", n, NPAT);
        else passes++;
    endtask

    task automatic test_ignored_in_done();
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({done, busy, rsp_valid} !== 3'b100)
            $display("FAIL abort_in_done: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, rsp_valid);
        else passes++;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy, done, pi_o} !== {2'b10, 7'd0})
            $display("FAIL start_wins: got busy=%b done=%b pi=%0d, want 1 0 0", busy, done, pi_o);
        else passes++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, rsp_valid} !== 3'b000)
            $display("FAIL abort_in_settle: got busy=%b done=%b valid=%b, want 0 0 0", busy, done, rsp_valid);
        else passes++;
    endtask

    task automatic test_abort();
        int n;
        int vcount = 0;
        sweep(1'b0, 40, n);
        checks++;
        if (n !== 40) $display("FAIL abort_count: got %0d, want 40", n);
        else passes++;
        repeat (10) begin
            if (rsp_valid) vcount++;
            @(negedge clk);
        end
        checks++;
        if (vcount !== 0) $display("FAIL abort_no_more: got %0d valid cycles, want 0", vcount);
        else passes++;
        sweep(1'b0, 3, n);
        checks++;
        if (n !== 3) $display("FAIL restart_count: got %0d, want 3", n);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int vcount = 0;
        rsp_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(rsp_valid && rsp_pat == 7'd77) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 1000) $display("FAIL reach_77: got timeout, want pattern 77");
        else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rsp_valid, pi_o, rsp_pat, rsp_data} !== '0)
            $display("FAIL async_reset: got busy=%b done=%b valid=%b pi=%0d pat=%0d data=%0d, want all 0",
                     busy, done, rsp_valid, pi_o, rsp_pat, rsp_data);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || busy) vcount++;
        end
        checks++;
        if (vcount !== 0) $display("FAIL post_reset_idle: got %0d active cycles, want 0", vcount);
        else passes++;
    endtask

    task automatic test_small_settle3();
        int cyc = 0;
        int first = -1;
        int nresp = 0;
        int bad = 0;
        rsp_ready2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 40) begin
            if (rsp_valid2) begin
                if (first < 0) first = cyc;
                if (rsp_pat2 !== 1'(nresp) || rsp_data2 !== ~1'(nresp)) bad++;
                nresp++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (first !== 4) $display("FAIL small_latency: got %0d, want 4", first);
        else passes++;
        checks++;
        if (nresp !== 2) $display("FAIL small_count: got %0d, want 2", nresp);
        else passes++;
        checks++;
        if (bad !== 0) $display("FAIL small_data: got %0d bad responses, want 0", bad);
        else passes++;
        checks++;
        if ({done2, busy2} !== 2'b10) $display("FAIL small_done: got done=%b busy=%b, want 1 0", done2, busy2);
        else passes++;
    endtask

`ifdef SWEEP_HD_EN
    task automatic test_hd();
        int n;
        gold_inv = 1'b1;
        sweep(1'b0, -1, n);
        checks++;
        if (hd_sum !== 10'(NPAT)) $display("FAIL hd_inverted: got %0d, want %0d", hd_sum, NPAT);
        else passes++;
        gold_inv = 1'b0;
        sweep(1'b1, -1, n);
        checks++;
        if (hd_sum !== '0) $display("FAIL hd_match: got %0d, want 0", hd_sum);
        else passes++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rsp_ready = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
        rsp_ready2 = 1'b0;
`ifdef SWEEP_HD_EN
        gold_inv = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_full_sweep();
        test_ignored_in_done();
        test_random_ready();
        test_abort();
        test_reset_mid();
        test_small_settle3();
`ifdef SWEEP_HD_EN
        test_hd();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/partition_sweep.md
PARTITION_SWEEP -- requirements
Module: partition_sweep

Interface
REQ-001 Parameter NI, default 7: width of the stimulus bus driven to the partition under test.
REQ-002 Parameter NO, default 4: width of the partition response bus.
REQ-003 Parameter SETTLE, default 1: cycles between a stimulus change and response sampling; legal range 1..255.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: begin exhaustive sweep; sampled only in IDLE or DONE.
REQ-007 Port abort, input, 1: terminate sweep in progress.
REQ-008 Port busy, output, 1: high from accepted start until DONE or IDLE.
REQ-009 Port done, output, 1: level, high in DONE.
REQ-010 Port pi_o, output, NI: stimulus to the partition.
REQ-011 Port po_i, input, NO: partition response.
REQ-012 Port rsp_valid / rsp_ready, output / input, 1 each: response stream handshake.
REQ-013 Port rsp_pat, output, NI: stimulus pattern of the current response.
REQ-014 Port rsp_data, output, NO: sampled po_i for rsp_pat.

Function
REQ-015 FSM states IDLE, SETTLE, OUT, DONE shall be used; reset state IDLE.
REQ-016 start in IDLE/DONE: pattern=0, pi_o=0, settle counter=0, busy=1, done=0, next state SETTLE.
REQ-017 SETTLE: after SETTLE cycles, register rsp_data=po_i, rsp_pat=pattern, rsp_valid=1, go to OUT.
REQ-018 First rsp_valid asserts exactly SETTLE+1 cycles after the start cycle.
REQ-019 OUT: rsp_pat/rsp_data/rsp_valid held stable while rsp_ready=0.
REQ-020 OUT with rsp_ready=1, pattern < 2^NI-1: pattern+1, pi_o updated same edge, rsp_valid=0, go to SETTLE.
REQ-021 OUT with rsp_ready=1, pattern = 2^NI-1: go to DONE, busy=0, done=1, rsp_valid=0, pi_o held; no counter wrap.
REQ-022 With rsp_ready tied high, throughput is one response per SETTLE+1 cycles; exactly 2^NI responses per sweep, in ascending pattern order.
REQ-023 abort in SETTLE/OUT: next state IDLE, rsp_valid=0, busy=0, done=0, pi_o=0; abort has priority over a same-cycle handshake.
REQ-024 start while busy and abort in IDLE/DONE shall be ignored; start+abort in same cycle in IDLE/DONE: start wins.

Reset
REQ-025 rst_n low: state IDLE, pi_o=0, busy=0, done=0, rsp_valid=0, rsp_pat=0, rsp_data=0, counters 0, immediately and independent of clk.
REQ-026 Reset mid-sweep discards the sweep; no response emitted until a new start.

Configuration
REQ-027 Macro SWEEP_HD_EN defined: ports gold_i (input, NO) and hd_sum (output, NI+$clog2(NO+1)) exist; at each SETTLE-to-OUT sample hd_sum += popcount(po_i ^ gold_i); cleared on accepted start and on reset; held through DONE.
REQ-028 Macro SWEEP_HD_EN undefined: gold_i, hd_sum and accumulation logic absent; all other behaviour identical.

Structure
REQ-029 Package partition_sweep_pkg shall hold the state enum and popcount function.
REQ-030 One sub-module, sweep_hd_acc (XOR, popcount, accumulator), instantiated only under SWEEP_HD_EN.

Verification
REQ-031 NI=7, NO=4, SETTLE=1, 7-input adder model, rsp_ready=1, start -> 128 responses, rsp_pat 0..127, rsp_data matches model, done at 128th handshake + 1 cycle.
REQ-032 Random rsp_ready (50%) -> same 128 responses, rsp_pat/rsp_data stable during every stall.
REQ-033 abort at rsp_pat=40 concurrent with rsp_ready=1 -> no 41st response, IDLE next cycle, pi_o=0; new start restarts at 0.
REQ-034 rst_n low at pattern 77 -> all outputs 0 asynchronously; after release, no rsp_valid without start.
REQ-035 SETTLE=3, NI=1 -> first rsp_valid 4 cycles after start, exactly 2 responses, then done.
REQ-036 SWEEP_HD_EN, gold_i = model output with bit 0 inverted -> hd_sum=128 at done; gold_i = model output -> hd_sum=0.
